// File: rtl/freq_stepper_if.sv
// freq_stepper_if: optimiser step requests into freq_stepper, frequency word and gate drives out.
interface freq_stepper_if;
   logic        enable;
   logic        data_start;
   logic        freq_ready;
   logic        freq_set_up_down;
   logic        freq_opt;
   logic [19:0] freq;
   logic        limit_hit;
   logic        inc_pending;
   logic        gate_h;
   logic        gate_l;
   modport master (
      output enable, data_start, freq_ready, freq_set_up_down, freq_opt,
      input  freq, limit_hit, inc_pending, gate_h, gate_l
   );
   modport slave (
      input  enable, data_start, freq_ready, freq_set_up_down, freq_opt,
      output freq, limit_hit, inc_pending, gate_h, gate_l
   );
endinterface

// File: rtl/freq_stepper.sv
// freq_stepper: clamped coarse/fine frequency stepping plus an NCO that drives
// complementary dead-time-protected half-bridge gates at that frequency.
module freq_stepper #(
   parameter logic [19:0] F_START     = 20'h9C40,
   parameter logic [19:0] F_MIN       = 20'h7530,
   parameter logic [19:0] F_MAX       = 20'hC350,
   parameter logic [19:0] STEP_COARSE = 20'd100,
   parameter logic [19:0] STEP_FINE   = 20'd10,
   parameter logic [7:0]  INC_SCALE   = 8'd86,
   parameter int          PHASE_W     = 32,
   parameter logic [7:0]  DEAD_CYC    = 8'd25
) (
   input logic           clk,
   input logic           nrst,
   freq_stepper_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, PENDING} state_t;
   localparam logic [27:0] INC_START = 28'(F_START) * 28'(INC_SCALE);
   state_t             state, state_nxt;
   logic [20:0]        step, sum_up, sum_dn;
   logic               up_clamp, dn_clamp, limit_nxt, pend_nxt, wrap, m, m_q;
   logic [19:0]        freq_nxt;
   logic [27:0]        prod;
   logic [PHASE_W-1:0] phase, inc;
   logic [PHASE_W:0]   acc;
   logic [7:0]         cnt, cnt_nxt;
   always_comb begin
      step      = {1'b0, bus.freq_opt ? STEP_FINE : STEP_COARSE};
      sum_up    = {1'b0, bus.freq} + step;
      sum_dn    = {1'b0, bus.freq} - step;
      up_clamp  = sum_up > {1'b0, F_MAX};
      dn_clamp  = sum_dn[20] || sum_dn[19:0] < F_MIN;
      freq_nxt  = bus.data_start ? F_START : !bus.freq_ready ? bus.freq :
                  bus.freq_set_up_down ? (up_clamp ? F_MAX : sum_up[19:0]) : (dn_clamp ? F_MIN : sum_dn[19:0]);
      limit_nxt = bus.data_start ? 1'b0 : !bus.freq_ready ? bus.limit_hit :
                  bus.freq_set_up_down ? up_clamp : dn_clamp;
      acc       = {1'b0, phase} + {1'b0, inc};
      wrap      = state != IDLE && acc[PHASE_W];
      // a step landing on the wrap cycle itself must wait for the following wrap
      pend_nxt  = freq_nxt != bus.freq || (bus.inc_pending && !(state == PENDING && wrap));
      state_nxt = !bus.enable ? IDLE : pend_nxt ? PENDING : RUN;
      m         = phase[PHASE_W-1];
      cnt_nxt   = (state == IDLE || m != m_q) ? DEAD_CYC : cnt == '0 ? '0 : cnt - 8'd1;
      prod      = 28'(bus.freq) * 28'(INC_SCALE);
   end
   always_ff @(posedge clk or negedge nrst)
      if (!nrst) state <= IDLE;
      else state <= state_nxt;
   always_ff @(posedge clk or negedge nrst)
      if (!nrst) begin
         bus.freq        <= F_START;
         bus.limit_hit   <= 1'b0;
         bus.inc_pending <= 1'b0;
         bus.gate_h      <= 1'b0;
         bus.gate_l      <= 1'b0;
         phase           <= '0;
         inc             <= PHASE_W'(INC_START);
         cnt             <= DEAD_CYC;
         m_q             <= 1'b0;
      end else begin
         bus.freq        <= freq_nxt;
         bus.limit_hit   <= limit_nxt;
         bus.inc_pending <= pend_nxt;
         bus.gate_h      <= state_nxt != IDLE && m && cnt_nxt == '0;
         bus.gate_l      <= state_nxt != IDLE && !m && cnt_nxt == '0;
         phase           <= (state == IDLE || state_nxt == IDLE) ? '0 : acc[PHASE_W-1:0];
         if (state == PENDING && wrap) inc <= PHASE_W'(prod);
         cnt             <= cnt_nxt;
         m_q             <= m;
      end
endmodule

// File: tb/tb_freq_stepper.sv
// tb_freq_stepper: directed stimulus against a cycle model of freq_stepper built
// from the stepping, NCO and dead-time rules, plus literal expectations.
module tb_freq_stepper;
   logic clk = 1'b0;
   logic nrst = 1'b0;
   int checks = 0;
   int failures = 0;
   freq_stepper_if bus();
   freq_stepper dut (.clk(clk), .nrst(nrst), .bus(bus.slave));
   always #10 clk = ~clk;

   // model: run = enable seen at the previous edge; gates need 25 quiet cycles since the last reload
   logic [19:0] e_freq, nf;
   logic        e_lim, e_pend, e_gh, e_gl, e_run, e_pm, nl, wrap, rl;
   logic [31:0] e_ph, e_inc;
   logic [32:0] sum;
   int          cyc, e_lr, st, up_v, dn_v, since;
   always_comb begin
      st   = bus.freq_opt ? 10 : 100;
      up_v = int'(e_freq) + st;
      dn_v = int'(e_freq) - st;
      nf   = e_freq;
      nl   = e_lim;
      if (bus.data_start) begin
         nf = 20'd40000;
         nl = 1'b0;
      end else if (bus.freq_ready && bus.freq_set_up_down) begin
         nf = up_v > 50000 ? 20'd50000 : 20'(up_v);
         nl = up_v > 50000;
      end else if (bus.freq_ready) begin
         nf = dn_v < 30000 ? 20'd30000 : 20'(dn_v);
         nl = dn_v < 30000;
      end
      sum   = {1'b0, e_ph} + {1'b0, e_inc};
      wrap  = e_run && sum[32];
      rl    = !e_run || e_ph[31] != e_pm;
      since = rl ? 0 : cyc - e_lr;
   end
   always @(posedge clk or negedge nrst)
      if (!nrst) begin
         e_freq <= 20'd40000;
         e_lim  <= 1'b0;
         e_pend <= 1'b0;
         e_gh   <= 1'b0;
         e_gl   <= 1'b0;
         e_run  <= 1'b0;
         e_ph   <= '0;
         e_inc  <= 32'd3440000;
         e_pm   <= 1'b0;
         cyc    <= 0;
         e_lr   <= 0;
      end else begin
         e_freq <= nf;
         e_lim  <= nl;
         e_pend <= nf != e_freq || (e_pend && !wrap);
         if (e_pend && wrap) e_inc <= e_freq * 32'd86;
         e_ph   <= (e_run && bus.enable) ? sum[31:0] : 32'd0;
         e_run  <= bus.enable;
         e_pm   <= e_ph[31];
         cyc    <= cyc + 1;
         if (rl) e_lr <= cyc;
         e_gh   <= bus.enable && e_ph[31] && since >= 25;
         e_gl   <= bus.enable && !e_ph[31] && since >= 25;
      end

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask
   task automatic chk_rng(input string name, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d..%0d at %0t", name, act, lo, hi, $time);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic step(input logic up, input logic opt);
      bus.freq_ready = 1'b1;
      bus.freq_set_up_down = up;
      bus.freq_opt = opt;
      tick();
      bus.freq_ready = 1'b0;
   endtask
   task automatic wait_rise(output int n);
      logic p;
      n = 0;
      do begin
         p = bus.gate_l;
         tick();
         n++;
      end while (!(bus.gate_l && !p) && n < 3000);
   endtask
   task automatic rise_after_enable(output int n);
      bus.enable = 1'b1;
      n = 0;
      do begin
         tick();
         n++;
      end while (!bus.gate_l && n < 100);
   endtask

   initial begin
      int n;
      bus.enable = 1'b0;
      bus.data_start = 1'b0;
      bus.freq_ready = 1'b0;
      bus.freq_set_up_down = 1'b0;
      bus.freq_opt = 1'b0;
      fork
         forever begin
            @(negedge clk);
            chk("freq", bus.freq, e_freq);
            chk("limit_hit", bus.limit_hit, e_lim);
            chk("inc_pending", bus.inc_pending, e_pend);
            chk("gate_h", bus.gate_h, e_gh);
            chk("gate_l", bus.gate_l, e_gl);
            chk("overlap", bus.gate_h & bus.gate_l, 0);
         end
      join_none
      #35;
      chk("rst_freq", bus.freq, 40000);
      chk("rst_gates", {bus.gate_h, bus.gate_l}, 0);
      chk("rst_flags", {bus.limit_hit, bus.inc_pending}, 0);
      @(negedge clk);
      nrst = 1'b1;
      repeat (3) tick();
      rise_after_enable(n);
      chk("gl_rise", n, 26);
      chk("gh_at_rise", bus.gate_h, 0);
      wait_rise(n);
      wait_rise(n);
      chk_rng("period_40k", n, 1248, 1249);
      step(1'b1, 1'b0);
      chk("step_up", bus.freq, 40100);
      chk("pend_set", bus.inc_pending, 1);
      n = 0;
      while (bus.inc_pending && n < 2000) begin
         tick();
         n++;
      end
      chk("pend_clear", bus.inc_pending, 0);
      wait_rise(n);
      wait_rise(n);
      chk_rng("period_40k1", n, 1245, 1246);
      bus.data_start = 1'b1;
      tick();
      bus.data_start = 1'b0;
      chk("restart", bus.freq, 40000);
      repeat (99) step(1'b1, 1'b0);
      repeat (5) step(1'b1, 1'b1);
      chk("f49950", bus.freq, 49950);
      step(1'b1, 1'b0);
      chk("clamp_max", bus.freq, 50000);
      chk("clamp_max_lim", bus.limit_hit, 1);
      step(1'b1, 1'b0);
      chk("hold_max", bus.freq, 50000);
      chk("hold_max_lim", bus.limit_hit, 1);
      step(1'b0, 1'b1);
      chk("fine_down", bus.freq, 49990);
      chk("fine_down_lim", bus.limit_hit, 0);
      bus.data_start = 1'b1;
      tick();
      bus.data_start = 1'b0;
      repeat (50) step(1'b1, 1'b0);
      chk("f45000", bus.freq, 45000);
      bus.data_start = 1'b1;
      step(1'b1, 1'b0);
      bus.data_start = 1'b0;
      chk("start_wins", bus.freq, 40000);
      chk("start_wins_lim", bus.limit_hit, 0);
      repeat (100) step(1'b0, 1'b0);
      chk("f30000", bus.freq, 30000);
      chk("f30000_lim", bus.limit_hit, 0);
      step(1'b0, 1'b0);
      chk("clamp_min", bus.freq, 30000);
      chk("clamp_min_lim", bus.limit_hit, 1);
      n = 0;
      while (!bus.gate_h && n < 3000) begin
         tick();
         n++;
      end
      chk("gh_seen", bus.gate_h, 1);
      repeat (10) tick();
      bus.enable = 1'b0;
      step(1'b1, 1'b0);
      chk("dis_gh", bus.gate_h, 0);
      chk("dis_gl", bus.gate_l, 0);
      chk("dis_step", bus.freq, 30100);
      repeat (5) tick();
      chk("idle_gates", {bus.gate_h, bus.gate_l}, 0);
      rise_after_enable(n);
      chk("gl_rerise", n, 26);
      repeat (300) tick();
      repeat (3) step(1'b0, 1'b0);
      chk("pre_rst_lim", bus.limit_hit, 1);
      #5;
      nrst = 1'b0;
      #1;
      chk("arst_freq", bus.freq, 40000);
      chk("arst_gates", {bus.gate_h, bus.gate_l}, 0);
      chk("arst_flags", {bus.limit_hit, bus.inc_pending}, 0);
      @(negedge clk);
      nrst = 1'b1;
      repeat (5) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
